// File: rtl/mips_cpu_multdiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mips_cpu_multdiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, div_by_zero, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mips_cpu_multdiv.sv
// Iterative shift-add multiply / restoring divide unit with HI/LO registers.
// Optional MIPS_CPU_MULTDIV_EARLY_TERM_EN: multiply stops once remaining multiplier bits are zero.
module mips_cpu_multdiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    mips_cpu_multdiv_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               res_neg;
    logic               rem_neg;
    logic               busy_d, done_d, dbz_d;

    // Operand decode and magnitude conversion in IDLE
    logic               op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;

    always_comb begin
        op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        a_neg     = op_signed && bus.a[WIDTH-1];
        b_neg     = op_signed && bus.b[WIDTH-1];
        a_abs     = a_neg ? -bus.a : bus.a;
        b_abs     = b_neg ? -bus.b : bus.b;
    end

    // Restoring step: trial subtract divisor from the shifted partial remainder
    logic [WIDTH:0]     trial;
    logic               mul_last;
    logic [2*WIDTH-1:0] prod_val;
    logic [WIDTH-1:0]   quo_val, rem_val;

    always_comb begin
        trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand[WIDTH-1:0]};
`ifdef MIPS_CPU_MULTDIV_EARLY_TERM_EN
        mul_last = (cnt == CW'(1)) || (mplier[WIDTH-1:1] == '0);
`else
        mul_last = (cnt == CW'(1));
`endif
        prod_val = res_neg ? -acc : acc;
        quo_val  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_val  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: state_next = S_MUL;
                        OP_DIV, OP_DIVU:   state_next = (bus.b == '0) ? S_DONE : S_DIV;
                        OP_MTHI, OP_MTLO:  state_next = S_DONE;
                        default:           state_next = S_IDLE;
                    endcase
                end
            end
            S_MUL:   if (mul_last) state_next = S_FIX;
            S_DIV:   if (cnt == CW'(1)) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next values of the registered status outputs
    always_comb begin
        busy_d = (state_next == S_MUL) || (state_next == S_DIV) || (state_next == S_FIX);
        done_d = (state_next == S_DONE);
        dbz_d  = (state == S_IDLE) && bus.start && op_div && (bus.b == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc             <= '0;
            mcand           <= '0;
            mplier          <= '0;
            cnt             <= '0;
            is_div          <= 1'b0;
            res_neg         <= 1'b0;
            rem_neg         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.busy        <= busy_d;
            bus.done        <= done_d;
            bus.div_by_zero <= dbz_d;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc     <= op_div ? {{WIDTH{1'b0}}, a_abs} : '0;
                        mcand   <= {{WIDTH{1'b0}}, (op_div ? b_abs : a_abs)};
                        mplier  <= b_abs;
                        cnt     <= CW'(WIDTH);
                        is_div  <= op_div;
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        if (bus.op == OP_MTHI) bus.hi <= bus.a;
                        if (bus.op == OP_MTLO) bus.lo <= bus.a;
                    end
                end
                S_MUL: begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                end
                S_DIV: begin
                    acc <= trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    if (is_div) begin
                        bus.hi <= rem_val;
                        bus.lo <= quo_val;
                    end else begin
                        bus.hi <= prod_val[2*WIDTH-1:WIDTH];
                        bus.lo <= prod_val[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Randomised and directed check of mips_cpu_multdiv against a plain-arithmetic reference model.
module tb_mips_cpu_multdiv;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset_n;

    mips_cpu_multdiv_if #(.WIDTH(W)) bus ();
    mips_cpu_multdiv #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for done, compare against the model; optional second
    // start pulse (MULT 2x2) injected on cycle inj while the first is in flight.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj);
        logic signed [63:0] sa, sb, p, q, r;
        logic [63:0] up;
        logic [W-1:0] ehi, elo, mb;
        logic edbz;
        int lat, it, cyc, nbusy;
        string tag;
        ehi = mhi; elo = mlo; edbz = 1'b0; lat = 1;
        sa = 64'(signed'(a)); sb = 64'(signed'(b));
        case (op)
            3'd0: begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; lat = W + 2; end
            3'd1: begin up = {32'b0, a} * {32'b0, b}; ehi = up[63:32]; elo = up[31:0]; lat = W + 2; end
            3'd2: if (b == '0) edbz = 1'b1;
                  else begin q = sa / sb; r = sa % sb; elo = q[31:0]; ehi = r[31:0]; lat = W + 2; end
            3'd3: if (b == '0) edbz = 1'b1;
                  else begin elo = a / b; ehi = a % b; lat = W + 2; end
            3'd4: ehi = a;
            3'd5: elo = a;
            default: ;
        endcase
`ifdef MIPS_CPU_MULTDIV_EARLY_TERM_EN
        if (op == 3'd0 || op == 3'd1) begin
            mb = (op == 3'd0 && b[W-1]) ? -b : b;
            it = 1;
            for (int i = 0; i < int'(W); i++) if (mb[i]) it = i + 1;
            lat = it + 2;
        end
`endif
        tag = $sformatf("op%0d a=%0h b=%0h", op, a, b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; nbusy = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (bus.busy === 1'b1) nbusy++;
            if (cyc == inj) begin bus.start = 1'b1; bus.op = 3'd0; bus.a = 2; bus.b = 2; end
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        check({tag, " done"}, 64'(bus.done), 64'(1));
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " busy_cycles"}, 64'(nbusy), 64'(lat - 1));
        check({tag, " busy_in_done"}, 64'(bus.busy), 64'(0));
        check({tag, " dbz"}, 64'(bus.div_by_zero), 64'(edbz));
        check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, " lo"}, 64'(bus.lo), 64'(elo));
        mhi = ehi; mlo = elo;
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        int ndone;
        reset_n = 1'b0; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset dbz", 64'(bus.div_by_zero), 64'(0));
        check("reset hi", 64'(bus.hi), 64'(0));
        check("reset lo", 64'(bus.lo), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'd5, 32'd3, 0);
        run_op(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(3'd4, 32'h11, 32'd0, 0);
        run_op(3'd5, 32'h22, 32'd0, 0);
        run_op(3'd3, 32'd10, 32'd0, 0);
        run_op(3'd2, 32'd10, 32'd0, 0);
        run_op(3'd3, 32'd100, 32'd7, 5);
        run_op(3'd0, 32'd9, 32'd0, 0);

        // Reserved opcodes are ignored
        bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'h55; bus.b = 32'h1;
        @(negedge clk);
        bus.op = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        check("reserved busy", 64'(bus.busy), 64'(0));
        check("reserved done", 64'(bus.done), 64'(0));
        check("reserved hi", 64'(bus.hi), 64'(mhi));
        check("reserved lo", 64'(bus.lo), 64'(mlo));

        for (int n = 0; n < 24; n++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: rb = -W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, 0);
        end

        // Reset mid-multiply aborts without a done pulse
        run_op(3'd4, 32'hABCD, 32'd0, 0);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort busy", 64'(bus.busy), 64'(0));
        check("abort hi", 64'(bus.hi), 64'(0));
        check("abort lo", 64'(bus.lo), 64'(0));
        mhi = '0; mlo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("abort no_done", 64'(ndone), 64'(0));
        check("abort hi_after", 64'(bus.hi), 64'(mhi));
        run_op(3'd1, 32'd12, 32'd12, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_cpu_multdiv.md
Name: mips_cpu_multdiv

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers, sitting beside the single-cycle ALU in the execute stage.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Uses a start/busy/done handshake so the pipeline stalls while busy is high.
- Multiply is shift-add and divide is restoring, each over WIDTH iterations.

Parameters:
- WIDTH, 32, operand width and HI/LO width; any value >= 4.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source
- b  in  WIDTH  rt operand: multiplier or divisor
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when hi/lo are updated (or when a divide by zero is rejected)
- div_by_zero  out  1  high together with done when a DIV/DIVU had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Internal accumulators are cleared.
  - Reset in any state aborts the operation with no hi/lo update.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start=1 with op 0/1 → MUL. Latch |a| and |b| (signed) or a and b (unsigned), plus the result sign. Counter=WIDTH, busy=1.
  - op 2/3 with b≠0 → DIV, set up the same way. Quotient sign = a xor b; remainder sign = sign of a.
  - op 2/3 with b==0 → DONE. hi/lo unchanged, div_by_zero=1.
  - op 4: hi<=a at this edge; → DONE.
  - op 5: lo<=a at this edge; → DONE.
  - op 6/7 ignored; stay in IDLE.
- MUL:
  - One multiplier bit per cycle; 2*WIDTH-bit product accumulator.
  - Counter decrements; on reaching 0 → FIX.
- DIV:
  - One restoring step per cycle: shift the remainder, trial subtract, set the quotient bit.
  - On counter 0 → FIX.
- FIX:
  - Apply two's-complement negation where required.
  - hi<=product[2W-1:W] and lo<=product[W-1:0]; for divides, hi<=remainder and lo<=quotient.
  - → DONE.
- DONE:
  - done=1 for exactly this cycle, busy=0; → IDLE.
  - start is not accepted in DONE; the next start is accepted in the following IDLE cycle.
- Latency (start edge to done high): MULT/DIV take WIDTH+2 cycles (34 for WIDTH=32); MTHI/MTLO and divide-by-zero take 1 cycle.
- busy is high from the cycle after start through FIX. It is low in DONE and IDLE.
- hi/lo hold their old values until the FIX edge.
- start while busy=1 is ignored; operands are not re-sampled.
- Signed division:
  - Truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ -1 gives lo=most-negative, hi=0, with no flag.
- Arithmetic is modulo 2^WIDTH per register; there is no overflow exception.

Optional Feature:
- Macro: MIPS_CPU_MULTDIV_EARLY_TERM_EN.
- Defined:
  - MUL skips iterations once the remaining multiplier bits are all zero.
  - Iteration count = position of the highest set bit of the latched multiplier + 1, minimum 1.
  - MULT/MULTU latency becomes iterations+2.
  - Divide latency is unchanged.
- Undefined: multiply always takes WIDTH iterations.
- Results are identical in both builds.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 → done on the 34th cycle; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. With early-term defined, MULTU 5×3 → done after 4 cycles with hi=0, lo=15.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=10, b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO → done and div_by_zero one cycle later; hi=0x11, lo=0x22 unchanged.
- Start DIVU 100/7, then pulse start with MULT 2×2 at cycle 5 → second request ignored; lo=14, hi=2 at cycle 34.
- Start MULT, assert reset_n=0 at cycle 10 → busy=0, hi=lo=0 immediately; after release, no done pulse occurs.
